// File: rtl/wb_reg_bridge_pkg.sv
// Shared types and defaults for the registered Wishbone bridge.
//
// Contents:
//   state_e     - bridge FSM states (IDLE, REQ, RESP)
//   rsp_e       - upstream response kind (RSP_ACK, RSP_ERR, RSP_RTY)
//   TO_CYC_DEF  - default watchdog limit in REQ cycles
//   pick_rsp()  - resolves simultaneous slave responses, ERR > RTY > ACK
package wb_reg_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } rsp_e;

  localparam int unsigned TO_CYC_DEF = 255;

  // Only called when at least one response line is high, so ACK is the
  // fall-through case and does not need to be an argument.
  function automatic rsp_e pick_rsp(input logic err, input logic rty);
    if (err) begin
      return RSP_ERR;
    end else if (rty) begin
      return RSP_RTY;
    end
    return RSP_ACK;
  endfunction

endpackage

// File: rtl/wb_reg_bridge_wdog.sv
// Watchdog counter for the bridge's REQ state.
//
// Counts cycles while en is high and flags expiry in the cycle the count
// reaches TO_CYC-1, so a limit of N means the N-th REQ cycle is the last one.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       restart the count (bridge entering REQ)
//   en        count this cycle (bridge is in REQ)
//   expired   limit reached in the current cycle
module wb_reg_bridge_wdog
  import wb_reg_bridge_pkg::*;
#(
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // The bridge leaves REQ on expiry, so the count never needs to saturate.
  assign expired = en && (count == LAST);

endmodule

// File: rtl/wb_reg_bridge.sv
// Registered single-outstanding Wishbone bridge (upstream slave port WBS_*,
// downstream master port WBM_*). Every output is a flop, so no input reaches
// an output combinationally. A request is replayed downstream one cycle after
// it is sampled, and the downstream response comes back upstream through one
// more register stage as a single-cycle ACK, ERR or RTY pulse.
//
// Build option:
//   WB_REG_BRIDGE_WDOG_EN  when defined, a silent slave is timed out after
//                          TO_CYC cycles in REQ and answered with ERR.
//                          When undefined, REQ waits indefinitely.
//
// Ports:
//   CLK_I, RST_I                     clock, asynchronous active-high reset
//   WBS_CYC_I/STB_I/WE_I/ADR_I/
//   DAT_I/SEL_I                      upstream request
//   WBS_DAT_O/ACK_O/ERR_O/RTY_O      upstream response
//   WBM_CYC_O/STB_O/WE_O/ADR_O/
//   DAT_O/SEL_O                      downstream request (registered)
//   WBM_DAT_I/ACK_I/ERR_I/RTY_I      downstream response
module wb_reg_bridge
  import wb_reg_bridge_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 32,
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              WBS_CYC_I,
  input  logic              WBS_STB_I,
  input  logic              WBS_WE_I,
  input  logic [AW-1:0]     WBS_ADR_I,
  input  logic [DW-1:0]     WBS_DAT_I,
  input  logic [DW/8-1:0]   WBS_SEL_I,
  output logic [DW-1:0]     WBS_DAT_O,
  output logic              WBS_ACK_O,
  output logic              WBS_ERR_O,
  output logic              WBS_RTY_O,
  output logic              WBM_CYC_O,
  output logic              WBM_STB_O,
  output logic              WBM_WE_O,
  output logic [AW-1:0]     WBM_ADR_O,
  output logic [DW-1:0]     WBM_DAT_O,
  output logic [DW/8-1:0]   WBM_SEL_O,
  input  logic [DW-1:0]     WBM_DAT_I,
  input  logic              WBM_ACK_I,
  input  logic              WBM_ERR_I,
  input  logic              WBM_RTY_I
);

  // A zero limit would make the watchdog counter meaningless.
  if (TO_CYC == 0) begin : g_to_cyc_zero
    $error("wb_reg_bridge: TO_CYC must be at least 1");
  end

  state_e state;
  logic   start;
  logic   any_rsp;
  logic   expired;
  rsp_e   rsp_sel;

  assign start   = WBS_CYC_I & WBS_STB_I;
  assign any_rsp = WBM_ACK_I | WBM_ERR_I | WBM_RTY_I;
  assign rsp_sel = pick_rsp(WBM_ERR_I, WBM_RTY_I);

`ifdef WB_REG_BRIDGE_WDOG_EN
  logic wdog_clr;
  logic wdog_en;

  assign wdog_clr = (state == IDLE) && start;
  assign wdog_en  = (state == REQ);

  wb_reg_bridge_wdog #(
    .TO_CYC (TO_CYC)
  ) u_wdog (
    .clk     (CLK_I),
    .rst     (RST_I),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= IDLE;
      WBM_CYC_O <= 1'b0;
      WBM_STB_O <= 1'b0;
      WBM_WE_O  <= 1'b0;
      WBM_ADR_O <= '0;
      WBM_DAT_O <= '0;
      WBM_SEL_O <= '0;
      WBS_DAT_O <= '0;
      WBS_ACK_O <= 1'b0;
      WBS_ERR_O <= 1'b0;
      WBS_RTY_O <= 1'b0;
    end else begin
      case (state)
        // Request capture: the downstream request register is loaded here and
        // held unchanged until the response edge.
        IDLE: begin
          if (start) begin
            WBM_CYC_O <= 1'b1;
            WBM_STB_O <= 1'b1;
            WBM_WE_O  <= WBS_WE_I;
            WBM_ADR_O <= WBS_ADR_I;
            WBM_DAT_O <= WBS_DAT_I;
            WBM_SEL_O <= WBS_SEL_I;
            state     <= REQ;
          end else if (!WBS_CYC_I) begin
            // CYC stays up between beats of a block/RMW cycle and only
            // falls once the master releases the bus.
            WBM_CYC_O <= 1'b0;
          end
        end

        // Downstream wait: abort beats any response that arrives with it.
        REQ: begin
          if (!WBS_CYC_I) begin
            WBM_CYC_O <= 1'b0;
            WBM_STB_O <= 1'b0;
            state     <= IDLE;
          end else if (any_rsp) begin
            WBM_STB_O <= 1'b0;
            if (!WBM_WE_O) begin
              WBS_DAT_O <= WBM_DAT_I;
            end
            WBS_ACK_O <= (rsp_sel == RSP_ACK);
            WBS_ERR_O <= (rsp_sel == RSP_ERR);
            WBS_RTY_O <= (rsp_sel == RSP_RTY);
            state     <= RESP;
          end else if (expired) begin
            // Timed-out slave: release the downstream bus entirely.
            WBM_CYC_O <= 1'b0;
            WBM_STB_O <= 1'b0;
            WBS_ERR_O <= 1'b1;
            state     <= RESP;
          end
        end

        // Upstream response: one-cycle pulse, driven even if CYC dropped.
        RESP: begin
          WBS_ACK_O <= 1'b0;
          WBS_ERR_O <= 1'b0;
          WBS_RTY_O <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
